sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-requester, round-robin arbiter and sequencer for the 64-entry x 64-bit single-port SRAM array.
- Serialises read/write requests from two clients onto the one memory port and returns read data with a fixed latency.
- Contains a clear state machine that zero-fills the whole array after reset or on command.
- Sits between the client logic and the SRAM array; all memory control passes through it.

Parameters:
- BW_DATA, 64, data width of memory and each client.
- BW_ADDR, 6, address width; depth = 2**BW_ADDR.
- INIT_ON_RESET, 1, 1 = zero-fill the array automatically on reset release.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_clr  input  1  single-cycle pulse that starts a zero-fill.
- o_busy  output  1  high while a zero-fill is in progress.
- i_req  input  2  per-client request; bit k = client k.
- i_we  input  2  per-client write enable; 1 = write, 0 = read.
- i_addr  input  2*BW_ADDR  client k address at [k*BW_ADDR +: BW_ADDR].
- i_wdata  input  2*BW_DATA  client k write data at [k*BW_DATA +: BW_DATA].
- o_gnt  output  2  combinational grant, one-hot or zero.
- o_rvalid  output  2  one-hot; read data for client k valid this cycle.
- o_rdata  output  BW_DATA  registered read data, shared by both clients.
- o_mem_addr  output  BW_ADDR  SRAM address.
- o_mem_data  output  BW_DATA  SRAM write data.
- o_mem_wen  output  1  SRAM write enable, active-low.
- o_mem_oen  output  1  SRAM output enable, active-low.
- i_mem_data  input  BW_DATA  SRAM read data; valid the cycle after the read edge.

Behaviour:
- Reset values:
  - o_gnt = 0, o_rvalid = 0, o_rdata = 0.
  - o_busy = INIT_ON_RESET; FSM = ST_CLR if INIT_ON_RESET, else ST_IDLE.
  - Clear counter = 0, round-robin pointer rr = 0.
- FSM states:
  - ST_IDLE:
    - i_clr = 1 goes to ST_CLR and forces o_gnt = 0 in that cycle; clear has priority over requests.
    - Otherwise arbitrate.
  - ST_CLR:
    - Each cycle: o_mem_addr = counter, o_mem_data = 0, o_mem_wen = 0, o_mem_oen = 1; counter increments.
    - o_gnt = 0 and o_busy = 1 throughout.
    - After address 2**BW_ADDR-1 is written, next state = ST_IDLE and o_busy = 0 from that cycle; exactly 2**BW_ADDR write cycles.
    - i_clr is ignored in ST_CLR; no restart.
- Arbitration (ST_IDLE, i_clr = 0):
  - Only one request: grant it.
  - Both request: grant client rr.
  - On any grant, rr <= the non-granted client index.
  - No request: rr unchanged.
- Transfer:
  - A transfer is accepted at the rising edge where i_req[k] & o_gnt[k].
  - The memory port is driven combinationally from the granted client's addr/wdata/we.
  - Write: o_mem_wen = 0, o_mem_oen = 1; committed at that edge; no response.
  - Read: o_mem_wen = 1, o_mem_oen = 0.
- Idle port: o_mem_wen = 1, o_mem_oen = 1, o_mem_addr = 0, o_mem_data = 0.
- Read latency:
  - Read granted in cycle N; i_mem_data is sampled into o_rdata at the end of cycle N+1.
  - o_rvalid[k] = 1 in cycle N+2 for exactly one cycle.
  - Fully pipelined: back-to-back reads give back-to-back rvalid.
  - A 2-entry owner pipeline (valid bit + client id) tracks each read in flight.
- o_rdata holds its last value when o_rvalid = 0.
- Reads granted before i_clr complete normally during ST_CLR; the owner pipeline is not flushed.
- Read and write to the same address in consecutive cycles: the read returns the array contents at its grant edge; no forwarding.
- Reset asserted mid-clear or mid-read: all state returns immediately to reset values and in-flight rvalid is dropped.

Decomposition:
- Shared package: FSM state encodings ST_IDLE/ST_CLR, client-count constant (2), default widths.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin grant (req[1:0], rr -> gnt[1:0]).
- Pointer update, clear FSM and read pipeline stay in sram_arbiter.

Test Plan:
- Reset with INIT_ON_RESET = 1 -> o_busy high for exactly 64 cycles; 64 writes of data 0 to addresses 0..63 in order; a read of addr 0x2A then returns 0.
- Client0 writes 0xDEADBEEF_00000001 to 0x05; client1 reads 0x05 one cycle later -> o_rvalid = 2'b10 two cycles after the read grant, o_rdata = 0xDEADBEEF_00000001.
- Both clients hold i_req for 6 cycles with rr = 0 -> o_gnt sequence 01, 10, 01, 10, 01, 10.
- Client0 issues back-to-back reads of 0x00, 0x01, 0x02 (preloaded 0x10, 0x11, 0x12) -> o_rvalid = 01 for 3 consecutive cycles, data in order.
- Read granted, then i_clr pulsed next cycle -> the read's rvalid still arrives at N+2 with pre-clear data; o_gnt = 0 for 64 clear cycles; i_clr at clear cycle 10 does not extend o_busy.
- i_rstn dropped at clear cycle 30 and released -> clear restarts at addr 0 and runs a full 64 cycles; o_rvalid = 0 immediately at reset assertion.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared types and constants for the two-client SRAM arbiter.
//                Holds the FSM state encoding, the client count, the default
//                bus widths and a small id-to-one-hot helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arbiter_pkg;

    // Number of clients sharing the memory port. The arbiter and the read
    // owner pipeline are built for exactly two.
    localparam int c_N_CLIENTS   = 2;

    // Default widths: 64 entries of 64 bits.
    localparam int c_BW_DATA_DEF = 64;
    localparam int c_BW_ADDR_DEF = 6;

    // Sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // arbitrate client requests
        ST_CLR  = 1'b1    // zero-fill the whole array, one entry per cycle
    } state_t;

    // Convert a client id into its one-hot position on the 2-bit buses.
    function automatic logic [c_N_CLIENTS-1:0] client_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage : sram_arbiter_pkg
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Bundle of the client-side and memory-side signals of the
//                SRAM arbiter. The arbiter connects through the slave modport;
//                the client/memory environment uses the master modport.
//  Signals     : i_clr/o_busy      clear command and clear-in-progress flag
//                i_req/i_we        per-client request and write enable
//                i_addr/i_wdata    per-client address and write data (packed)
//                o_gnt             combinational one-hot grant
//                o_rvalid/o_rdata  read response (one-hot valid, shared data)
//                o_mem_*           SRAM address/data/enables (enables act-low)
//                i_mem_data        SRAM read data, one cycle after read edge
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int BW_DATA = sram_arbiter_pkg::c_BW_DATA_DEF,
    parameter int BW_ADDR = sram_arbiter_pkg::c_BW_ADDR_DEF
);
    import sram_arbiter_pkg::*;

    // Control
    logic                           i_clr;
    logic                           o_busy;

    // Client side
    logic [c_N_CLIENTS-1:0]         i_req;
    logic [c_N_CLIENTS-1:0]         i_we;
    logic [c_N_CLIENTS*BW_ADDR-1:0] i_addr;
    logic [c_N_CLIENTS*BW_DATA-1:0] i_wdata;
    logic [c_N_CLIENTS-1:0]         o_gnt;
    logic [c_N_CLIENTS-1:0]         o_rvalid;
    logic [BW_DATA-1:0]             o_rdata;

    // Memory side
    logic [BW_ADDR-1:0]             o_mem_addr;
    logic [BW_DATA-1:0]             o_mem_data;
    logic                           o_mem_wen;
    logic                           o_mem_oen;
    logic [BW_DATA-1:0]             i_mem_data;

    // Environment view: drives requests and SRAM read data.
    modport master (
        output i_clr, i_req, i_we, i_addr, i_wdata, i_mem_data,
        input  o_busy, o_gnt, o_rvalid, o_rdata,
               o_mem_addr, o_mem_data, o_mem_wen, o_mem_oen
    );

    // Arbiter view.
    modport slave (
        input  i_clr, i_req, i_we, i_addr, i_wdata, i_mem_data,
        output o_busy, o_gnt, o_rvalid, o_rdata,
               o_mem_addr, o_mem_data, o_mem_wen, o_mem_oen
    );

endinterface : sram_arbiter_if
`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Purely combinational two-way round-robin grant. A lone
//                request is always granted; when both clients request, the
//                client selected by the priority pointer wins.
//  Ports       : i_req[1:0]  request per client
//                i_rr        priority pointer (client index favoured on a tie)
//                o_gnt[1:0]  one-hot grant, or zero when nothing requests
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  wire logic [c_N_CLIENTS-1:0] i_req,
    input  wire logic                   i_rr,
    output logic      [c_N_CLIENTS-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = client_onehot(i_rr);
            default: o_gnt = '0;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-client round-robin arbiter and sequencer in front of a
//                single-port SRAM (2**BW_ADDR x BW_DATA). Serialises client
//                reads/writes onto the memory port, returns read data two
//                cycles after the grant, and zero-fills the whole array after
//                reset (optional) or on an i_clr pulse.
//  Ports       : i_clk   clock, rising edge
//                i_rstn  asynchronous active-low reset
//                bus     sram_arbiter_if.slave (client + memory signals)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int BW_DATA       = 64,
    parameter int BW_ADDR       = 6,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  wire logic     i_clk,
    input  wire logic     i_rstn,
    sram_arbiter_if.slave bus
);
    import sram_arbiter_pkg::*;

    // Last address written by a zero-fill.
    localparam logic [BW_ADDR-1:0] c_CNT_LAST = '1;
    // State entered on reset: straight into a clear when auto-init is on.
    localparam state_t c_RST_STATE = state_t'(INIT_ON_RESET ? ST_CLR : ST_IDLE);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BW_ADDR-1:0]     r_cnt;          // zero-fill address
    logic                   r_rr;           // client favoured on a tie

    // Read owner pipeline: stage 1 = memory access in progress,
    // stage 2 = data registered, response presented to the client.
    logic                   r_p1_vld;
    logic                   r_p1_id;
    logic                   r_p2_vld;
    logic                   r_p2_id;
    logic [BW_DATA-1:0]     r_rdata;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [c_N_CLIENTS-1:0] w_arb_gnt;      // raw arbiter decision
    logic [c_N_CLIENTS-1:0] w_gnt;          // grant after state/clear gating
    logic                   w_gnt_id;       // index of granted client
    logic                   w_sel_we;
    logic [BW_ADDR-1:0]     w_sel_addr;
    logic [BW_DATA-1:0]     w_sel_wdata;
    logic                   w_rd_accept;    // read accepted at this edge
    logic [BW_ADDR-1:0]     w_mem_addr;
    logic [BW_DATA-1:0]     w_mem_data;
    logic                   w_mem_wen;
    logic                   w_mem_oen;

    rr_arb2 u_rr_arb2 (
        .i_req (bus.i_req),
        .i_rr  (r_rr),
        .o_gnt (w_arb_gnt)
    );

    // Granted client's fields; only meaningful while w_gnt is non-zero.
    assign w_gnt_id    = w_gnt[1];
    assign w_sel_we    = w_gnt_id ? bus.i_we[1] : bus.i_we[0];
    assign w_sel_addr  = w_gnt_id ? bus.i_addr[2*BW_ADDR-1:BW_ADDR]
                                  : bus.i_addr[BW_ADDR-1:0];
    assign w_sel_wdata = w_gnt_id ? bus.i_wdata[2*BW_DATA-1:BW_DATA]
                                  : bus.i_wdata[BW_DATA-1:0];
    assign w_rd_accept = (|w_gnt) & ~w_sel_we;

    // ------------------------------------------------------------------------
    // Next state, grant and memory port
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_mem_addr  = '0;
        w_mem_data  = '0;
        w_mem_wen   = 1'b1;
        w_mem_oen   = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                // A clear command wins over any request in the same cycle,
                // so nothing is granted on the transition cycle.
                if (bus.i_clr) begin
                    w_state_nxt = ST_CLR;
                end else begin
                    w_gnt = w_arb_gnt;
                    if (|w_arb_gnt) begin
                        w_mem_addr = w_sel_addr;
                        w_mem_data = w_sel_wdata;
                        w_mem_wen  = ~w_sel_we;
                        w_mem_oen  = w_sel_we;
                    end
                end
            end

            ST_CLR: begin
                // One zero write per cycle; i_clr has no effect here.
                w_mem_addr = r_cnt;
                w_mem_wen  = 1'b0;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and counter
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // The counter wraps back to zero on the last clear write, so each
            // clear starts from address 0 without an explicit reload.
            if (r_state == ST_CLR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pointer: after a grant, the other client gets priority.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rr <= 1'b0;
        end else if (|w_gnt) begin
            r_rr <= ~w_gnt_id;
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline. Not flushed by a clear: reads granted just before a
    // clear still return the data read at their grant edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_p1_vld <= 1'b0;
            r_p1_id  <= 1'b0;
            r_p2_vld <= 1'b0;
            r_p2_id  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_p1_vld <= w_rd_accept;
            r_p1_id  <= w_gnt_id;
            r_p2_vld <= r_p1_vld;
            r_p2_id  <= r_p1_id;
            // SRAM output is valid the cycle after the read edge; capture it
            // then and hold it otherwise.
            if (r_p1_vld) begin
                r_rdata <= bus.i_mem_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.o_busy     = (r_state == ST_CLR);
    assign bus.o_gnt      = w_gnt;
    assign bus.o_rvalid   = r_p2_vld ? client_onehot(r_p2_id) : '0;
    assign bus.o_rdata    = r_rdata;
    assign bus.o_mem_addr = w_mem_addr;
    assign bus.o_mem_data = w_mem_data;
    assign bus.o_mem_wen  = w_mem_wen;
    assign bus.o_mem_oen  = w_mem_oen;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter. Includes a behavioural
//                SRAM, a reference copy of the array, a read scoreboard and a
//                vector table for arbitration/transfer cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;
    localparam int DEPTH   = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus ();

    sram_arbiter #(
        .BW_DATA       (BW_DATA),
        .BW_ADDR       (BW_ADDR),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    // ---------------- behavioural SRAM ----------------
    logic [BW_DATA-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!bus.o_mem_oen) bus.i_mem_data <= sram[bus.o_mem_addr];
        if (!bus.o_mem_wen) sram[bus.o_mem_addr] <= bus.o_mem_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference state and scoreboard ----------------
    logic [BW_DATA-1:0] ref_mem [DEPTH];

    typedef struct {
        int                 due;
        logic               id;
        logic [BW_DATA-1:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [1:0]         req;
        logic [1:0]         we;
        logic [5:0]         a0;
        logic [5:0]         a1;
        logic [BW_DATA-1:0] d0;
        logic [BW_DATA-1:0] d1;
        logic [1:0]         gnt;
    } vec_t;
    vec_t tbl[19];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-response monitor, run once per cycle at the falling edge.
    task automatic mon();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            rd_exp_t e;
            e = sb.pop_front();
            chk("rvalid", 64'(bus.o_rvalid), e.id ? 64'd2 : 64'd1);
            chk("rdata", bus.o_rdata, e.data);
        end else if (bus.o_rvalid != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got %b required 00 (cycle %0d)", bus.o_rvalid, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                                input logic [5:0] a0, input logic [5:0] a1,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [1:0] gnt);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.gnt = gnt;
        return v;
    endfunction

    // Drive one cycle of client stimulus and check grant and memory port.
    task automatic apply(input vec_t v);
        logic        k;
        logic [5:0]  ea;
        logic [63:0] ed;
        bus.i_req   = v.req;
        bus.i_we    = v.we;
        bus.i_addr  = {v.a1, v.a0};
        bus.i_wdata = {v.d1, v.d0};
        k  = v.gnt[1];
        ea = k ? v.a1 : v.a0;
        ed = k ? v.d1 : v.d0;
        #1;
        chk("gnt", 64'(bus.o_gnt), 64'(v.gnt));
        if (v.gnt == 2'b00) begin
            chk("idle_addr", 64'(bus.o_mem_addr), 64'd0);
            chk("idle_data", bus.o_mem_data, 64'd0);
            chk("idle_wen", 64'(bus.o_mem_wen), 64'd1);
            chk("idle_oen", 64'(bus.o_mem_oen), 64'd1);
        end else begin
            chk("mem_addr", 64'(bus.o_mem_addr), 64'(ea));
            if (v.we[k]) begin
                chk("wr_wen", 64'(bus.o_mem_wen), 64'd0);
                chk("wr_oen", 64'(bus.o_mem_oen), 64'd1);
                chk("wr_data", bus.o_mem_data, ed);
            end else begin
                chk("rd_wen", 64'(bus.o_mem_wen), 64'd1);
                chk("rd_oen", 64'(bus.o_mem_oen), 64'd0);
                sb.push_back('{due: cyc + 2, id: k, data: ref_mem[ea]});
            end
        end
        step();
        if (v.gnt != 2'b00 && v.we[k]) ref_mem[ea] = ed;
        bus.i_req = 2'b00;
    endtask

    // Walk a zero-fill, checking every write; stops early at stop_at.
    task automatic clear_run(input int pulse_at, input int stop_at, output int n);
        n = 0;
        bus.i_req = 2'b11;
        bus.i_we  = 2'b00;
        while (bus.o_busy && n < 200 && n != stop_at) begin
            #1;
            chk("clr_addr", 64'(bus.o_mem_addr), 64'(n[5:0]));
            chk("clr_data", bus.o_mem_data, 64'd0);
            chk("clr_wen", 64'(bus.o_mem_wen), 64'd0);
            chk("clr_oen", 64'(bus.o_mem_oen), 64'd1);
            chk("clr_gnt", 64'(bus.o_gnt), 64'd0);
            bus.i_clr = (n == pulse_at);
            step();
            n++;
        end
        bus.i_clr = 1'b0;
        bus.i_req = 2'b00;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom, $urandom};
        bus.i_mem_data <= '0;
        bus.i_clr   = 1'b0;
        bus.i_req   = 2'b00;
        bus.i_we    = 2'b00;
        bus.i_addr  = '0;
        bus.i_wdata = '0;

        tbl[0]  = mk(2'b01, 2'b00, 6'h2A, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[1]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 64'h0, 64'h0, 2'b00);
        tbl[2]  = mk(2'b01, 2'b01, 6'h05, 6'h00, 64'hDEADBEEF_00000001, 64'h0, 2'b01);
        tbl[3]  = mk(2'b10, 2'b00, 6'h00, 6'h05, 64'h0, 64'h0, 2'b10);
        tbl[4]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 64'h0, 64'h0, 2'b00);
        tbl[5]  = mk(2'b11, 2'b11, 6'h00, 6'h01, 64'h10, 64'h11, 2'b01);
        tbl[6]  = mk(2'b11, 2'b11, 6'h02, 6'h01, 64'h12, 64'h11, 2'b10);
        tbl[7]  = mk(2'b11, 2'b11, 6'h02, 6'h03, 64'h12, 64'h13, 2'b01);
        tbl[8]  = mk(2'b11, 2'b11, 6'h04, 6'h03, 64'h14, 64'h13, 2'b10);
        tbl[9]  = mk(2'b11, 2'b00, 6'h05, 6'h2A, 64'h0, 64'h0, 2'b01);
        tbl[10] = mk(2'b11, 2'b00, 6'h05, 6'h2A, 64'h0, 64'h0, 2'b10);
        tbl[11] = mk(2'b01, 2'b00, 6'h00, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[12] = mk(2'b01, 2'b00, 6'h01, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[13] = mk(2'b01, 2'b00, 6'h02, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[14] = mk(2'b10, 2'b10, 6'h00, 6'h07, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 2'b10);
        tbl[15] = mk(2'b01, 2'b00, 6'h07, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[16] = mk(2'b10, 2'b10, 6'h00, 6'h07, 64'h0, 64'h1234, 2'b10);
        tbl[17] = mk(2'b01, 2'b00, 6'h07, 6'h00, 64'h0, 64'h0, 2'b01);
        tbl[18] = mk(2'b00, 2'b00, 6'h00, 6'h00, 64'h0, 64'h0, 2'b00);

        // ---- reset values, then automatic zero-fill ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(bus.o_gnt), 64'd0);
        chk("rst_rvalid", 64'(bus.o_rvalid), 64'd0);
        chk("rst_rdata", bus.o_rdata, 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd1);
        rstn = 1'b1;
        clear_run(-1, -1, n);
        chk("init_clear_cycles", 64'(n), 64'd64);
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // ---- arbitration / transfer table ----
        for (int i = 0; i < 19; i++) apply(tbl[i]);

        // ---- read, then clear pulsed the next cycle ----
        apply(mk(2'b10, 2'b10, 6'h00, 6'h10, 64'h0, 64'hCAFEF00D_12345678, 2'b10));
        apply(mk(2'b01, 2'b00, 6'h10, 6'h00, 64'h0, 64'h0, 2'b01));
        bus.i_clr = 1'b1;
        bus.i_req = 2'b11;
        #1;
        chk("clr_cycle_gnt", 64'(bus.o_gnt), 64'd0);
        chk("clr_cycle_busy", 64'(bus.o_busy), 64'd0);
        step();
        bus.i_clr = 1'b0;
        clear_run(10, -1, n);
        chk("cmd_clear_cycles", 64'(n), 64'd64);
        foreach (ref_mem[i]) ref_mem[i] = '0;
        apply(mk(2'b01, 2'b00, 6'h10, 6'h00, 64'h0, 64'h0, 2'b01));

        // ---- reset while a read response is on the bus ----
        apply(mk(2'b01, 2'b01, 6'h05, 6'h00, 64'h5555AAAA_0F0F0F0F, 64'h0, 2'b01));
        bus.i_req  = 2'b10;
        bus.i_we   = 2'b00;
        bus.i_addr = {6'h05, 6'h00};
        #1;
        chk("manual_rd_gnt", 64'(bus.o_gnt), 64'd2);
        step();
        bus.i_req = 2'b00;
        step();
        chk("pre_rst_rvalid", 64'(bus.o_rvalid), 64'd2);
        chk("pre_rst_rdata", bus.o_rdata, 64'h5555AAAA_0F0F0F0F);
        rstn = 1'b0;
        #1;
        chk("rst_drop_rvalid", 64'(bus.o_rvalid), 64'd0);
        chk("rst_drop_rdata", bus.o_rdata, 64'd0);
        chk("rst_drop_busy", 64'(bus.o_busy), 64'd1);
        sb.delete();
        repeat (2) step();
        rstn = 1'b1;

        // ---- reset in the middle of a clear ----
        clear_run(-1, 30, n);
        chk("partial_clear_cycles", 64'(n), 64'd30);
        rstn = 1'b0;
        #1;
        chk("midclr_rst_addr", 64'(bus.o_mem_addr), 64'd0);
        chk("midclr_rst_busy", 64'(bus.o_busy), 64'd1);
        step();
        rstn = 1'b1;
        clear_run(-1, -1, n);
        chk("restart_clear_cycles", 64'(n), 64'd64);
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Pointer is back at client 0 after reset.
        apply(mk(2'b11, 2'b00, 6'h05, 6'h06, 64'h0, 64'h0, 2'b01));
        apply(mk(2'b10, 2'b00, 6'h05, 6'h06, 64'h0, 64'h0, 2'b10));

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
